tdm_demux_2ch: RTL
==================

Name: tdm_demux_2ch

Overview:
Receive-side two-channel time-division demultiplexer, the far end of a 2:1 bit-interleaving mux link. Accepts a serial bit stream alternating channel A and channel B bits, LSB first, framed by a sync pulse. Deserializes each frame into one WIDTH-bit word per channel and presents both words with a one-cycle valid strobe. Sits between the serial link input and the per-channel word consumers.

Parameters:
WIDTH, 8, bits per channel word; one frame is 2*WIDTH bits.

Ports:
clk  input  1  clock; all sampling on rising edge
rst  input  1  asynchronous, active-high reset
din  input  1  serial data bit
din_valid  input  1  din is sampled only when high
frame_sync  input  1  qualified by din_valid; marks the current bit as frame bit 0 (channel A, bit 0)
out_a  output  WIDTH  last complete channel A word
out_b  output  WIDTH  last complete channel B word
out_valid  output  1  one-cycle strobe: out_a/out_b updated
sel_cur  output  1  channel of the next expected bit (0=A, 1=B); mirrors the transmit mux select
locked  output  1  high while in RECV
sync_err  output  1  one-cycle strobe: frame_sync seen at a non-zero bit index

Behaviour:
- Reset (async, any time, including mid-frame): state=HUNT, bit counter=0, shift registers=0, out_a=0, out_b=0, out_valid=0, sel_cur=0, locked=0, sync_err=0. Partial frame discarded; no out_valid.
- Accepted bit = rising edge with din_valid=1. Edges with din_valid=0 change nothing except clearing the out_valid/sync_err strobes.
- Bit counter idx: 0..2*WIDTH-1; channel = idx[0] (even=A, odd=B); bit position within word = idx>>1. sel_cur = idx[0].
- HUNT: accepted bits without frame_sync are dropped. Accepted bit with frame_sync=1: taken as idx 0 (A bit 0), counter->1, state->RECV, locked=1 from the next cycle.
- RECV: each accepted bit written to position idx>>1 of the A or B shift register; counter increments.
  - Bit at idx 2*WIDTH-1: on that edge out_a/out_b load the completed words (including this bit), out_valid=1 for exactly the following cycle, counter wraps to 0, stays RECV.
  - At idx 0 frame_sync is optional; absence does not drop lock (free-running framing).
  - frame_sync=1 at idx!=0: sync_err=1 for one cycle, partial frame discarded (no out_valid), this bit taken as new idx 0, counter->1, stays RECV.
- Latency: out_valid asserts in the cycle after the edge sampling the final bit of a frame. Back-to-back frames with continuous din_valid give out_valid once every 2*WIDTH cycles.
- out_a/out_b hold their values between strobes.
- din_valid gaps of any length mid-frame stall the frame; no timeout.

Test Plan:
- Reset then one frame, WIDTH=8, din_valid=1 continuous, frame_sync on first bit; stream 1,0,0,0,1,1,0,1,0,1,1,1,0,0,1,0 -> out_a=0xA5, out_b=0x3C, out_valid high exactly one cycle after 16th bit, locked=1, sync_err=0.
- Idle/junk bits without frame_sync before sync -> no capture, locked=0; then frame above -> same result.
- Same frame with din_valid=0 inserted for 3 cycles after bits 5 and 11 -> identical words; out_valid one cycle after 16th accepted bit; sel_cur frozen during gaps.
- Two back-to-back frames (0xA5/0x3C then 0xFF/0x00), sync only on first -> two strobes 16 cycles apart, second yields out_a=0xFF, out_b=0x00.
- frame_sync re-asserted at bit 6 of a frame, then a full frame from there -> sync_err one-cycle pulse, no out_valid for aborted frame, next strobe 16 accepted bits after the resync bit with correct words.
- rst asserted asynchronously at bit 9 -> outputs to 0 immediately, locked=0; post-reset bits ignored until frame_sync.

Source files
------------

// File: rtl/tdm_demux_2ch.sv
// rtl/tdm_demux_2ch.sv - two-channel bit-interleaved TDM receive demultiplexer
module tdm_demux_2ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  output logic             sel_cur,
  output logic             locked,
  output logic             sync_err
);

  localparam int FRAME = 2 * WIDTH;
  localparam int IW    = $clog2(FRAME);
  localparam logic [IW-1:0] LAST = IW'(FRAME - 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_out_a;
  logic [WIDTH-1:0] r_out_b;
  logic             r_out_valid;
  logic             r_sync_err;

  logic [IW-2:0]    w_pos;
  logic [WIDTH-1:0] w_sh_a;
  logic [WIDTH-1:0] w_sh_b;
  logic [WIDTH-1:0] w_fresh_a;

  // Bit position within the word is the counter without its channel bit.
  assign w_pos     = r_idx[IW-1:1];
  assign w_fresh_a = {{(WIDTH-1){1'b0}}, din};

  // Shift registers as they look with the current bit written in, so the
  // last bit of a frame can be included in the word loaded on the same edge.
  always_comb begin
    w_sh_a = r_sh_a;
    w_sh_b = r_sh_b;
    if (r_idx[0]) w_sh_b[w_pos] = din;
    else          w_sh_a[w_pos] = din;
  end

  // Framing state, bit counter, deserializers and output word/strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_idx       <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (din_valid) begin
        if (r_state == HUNT) begin
          // Drop everything until a sync marks channel A bit 0.
          if (frame_sync) begin
            r_state <= RECV;
            r_idx   <= IW'(1);
            r_sh_a  <= w_fresh_a;
            r_sh_b  <= '0;
          end
        end else if (frame_sync && (r_idx != '0)) begin
          // Misplaced sync: abandon the partial frame and restart on this bit.
          r_sync_err <= 1'b1;
          r_idx      <= IW'(1);
          r_sh_a     <= w_fresh_a;
          r_sh_b     <= '0;
        end else begin
          // Framing free-runs; a sync at index 0 is accepted but not required.
          r_sh_a <= w_sh_a;
          r_sh_b <= w_sh_b;
          if (r_idx == LAST) begin
            r_idx       <= '0;
            r_out_a     <= w_sh_a;
            r_out_b     <= w_sh_b;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end
    end
  end

  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_valid = r_out_valid;
  assign sel_cur   = r_idx[0];
  assign locked    = (r_state == RECV);
  assign sync_err  = r_sync_err;

endmodule
